// File: rtl/xadc_scan_pwm_pkg.sv
// xadc_scan_pkg: shared types and helpers for the XADC scanner / PWM block.
//   - scan_state_e : scanner FSM states
//   - AUX0_ADDR / AUX12_ADDR : DRP status-register addresses of VAUX0 / VAUX12
//   - CODE_W       : XADC conversion code width
//   - next_enabled : round-robin search for the next enabled channel index
package xadc_scan_pkg;

    localparam int CODE_W = 12;

    localparam logic [6:0] AUX0_ADDR  = 7'h10;
    localparam logic [6:0] AUX12_ADDR = 7'h1C;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RDY,
        STORE
    } scan_state_e;

    // Returns the first enabled index strictly after cur (mod n). The last
    // candidate checked is cur itself, so a lone enabled cur stays put and
    // an all-disabled mask also returns cur.
    function automatic logic [2:0] next_enabled(
        input logic [7:0] en,
        input logic [2:0] cur,
        input int         n
    );
        logic [2:0] res;
        logic       found;
        int         idx;
        res   = cur;
        found = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            idx = int'(cur) + k;
            if (idx >= n) idx = idx - n;
            if (!found && (k <= n) && en[idx[2:0]]) begin
                res   = idx[2:0];
                found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/xadc_scan_pwm_if.sv
// xadc_scan_pwm_if: DRP and end-of-conversion signals between the scanner
// and xadc_wiz_0.
//   master (scanner): drives den/daddr, receives eoc/channel/drdy/do_in
//   slave  (XADC)   : the mirror image
interface xadc_scan_pwm_if;
    logic        eoc;
    logic [4:0]  channel;
    logic        drdy;
    logic [15:0] do_in;
    logic        den;
    logic [6:0]  daddr;

    modport master (input eoc, channel, drdy, do_in, output den, daddr);
    modport slave  (output eoc, channel, drdy, do_in, input den, daddr);
endinterface

// File: rtl/xadc_pwm_ch.sv
// xadc_pwm_ch: one LED PWM comparator.
//   clk, rst_n : clock and asynchronous active-low reset
//   wrap_i     : one-cycle pulse in the last counter cycle of each period
//   cnt_i      : shared free-running PWM counter
//   code_i     : 12-bit conversion code for this channel
//   en_i       : channel enable (gates the output)
//   led_o      : registered PWM output, active high
// Codes below DEADBAND give duty 0. The active duty is reloaded only at the
// period boundary so a code change never truncates or stretches a pulse.
module xadc_pwm_ch #(
    parameter int PWM_W    = 12,
    parameter int DEADBAND = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wrap_i,
    input  logic [PWM_W-1:0] cnt_i,
    input  logic [11:0]      code_i,
    input  logic             en_i,
    output logic             led_o
);
    logic [PWM_W-1:0] aligned;
    logic [PWM_W-1:0] duty_d;
    logic [PWM_W-1:0] duty_act_q;
    logic             led_q;

    generate
        if (PWM_W == 12) begin : g_eq
            assign aligned = code_i;
        end else if (PWM_W > 12) begin : g_wide
            assign aligned = {code_i, {(PWM_W-12){1'b0}}};
        end else begin : g_narrow
            assign aligned = code_i[11 -: PWM_W];
        end
    endgenerate

    assign duty_d = (int'(code_i) < DEADBAND) ? '0 : aligned;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_act_q <= '0;
            led_q      <= 1'b0;
        end else begin
            if (wrap_i) duty_act_q <= duty_d;
            led_q <= en_i & (cnt_i < duty_act_q);
        end
    end

    assign led_o = led_q;
endmodule

// File: rtl/xadc_scan_pwm.sv
// xadc_scan_pwm: round-robin XADC DRP scanner feeding N_CH LED PWM outputs.
//   clk, rst_n : clock, asynchronous active-low reset
//   ch_en      : per-channel enable
//   drp        : eoc/channel/drdy/do_in in, den/daddr out (xadc_scan_pwm_if)
//   smp_valid/smp_ch/smp_code : one-cycle strobe with channel index and code
//   tmo_err    : sticky DRP timeout flag
//   led        : PWM outputs
// Optional macro XADC_SCAN_AVG_EN: publish a 4-sample running average per
// channel instead of the raw code.
// Default CH_ADDR puts VAUX12 (7'h1C) on channel 0 and VAUX0 (7'h10) on
// channel 1.
module xadc_scan_pwm
    import xadc_scan_pkg::*;
#(
    parameter int                N_CH     = 2,
    parameter logic [N_CH*7-1:0] CH_ADDR  = {AUX0_ADDR, AUX12_ADDR},
    parameter int                PWM_W    = 12,
    parameter int                DEADBAND = 16,
    parameter int                TMO      = 63
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_CH-1:0]    ch_en,
    xadc_scan_pwm_if.master    drp,
    output logic               smp_valid,
    output logic [2:0]         smp_ch,
    output logic [CODE_W-1:0]  smp_code,
    output logic               tmo_err,
    output logic [N_CH-1:0]    led
);
    localparam int TMO_W = (TMO < 2) ? 1 : $clog2(TMO + 1);

    scan_state_e       state_q, state_d;
    logic [2:0]        cur_q, cur_d;
    logic [6:0]        daddr_q, daddr_d;
    logic              den_q, den_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic [11:0]       data_q;
    logic [4:0]        chan_q;
    logic              smp_valid_q;
    logic [2:0]        smp_ch_q;
    logic [11:0]       smp_code_q;
    logic              tmo_err_q;
    logic [PWM_W-1:0]  pwm_cnt_q;
    logic              cap, store_hit, tmo_hit, wrap;
    logic [7:0]        en_pad;
    logic [2:0]        sel_idx, adv_idx;
    logic [6:0]        ch_addr [8];
    logic [11:0]       new_code;
    logic              unused_ok;

    assign unused_ok = &{1'b0, drp.do_in[3:0]};
    assign en_pad    = 8'(ch_en);
    // At eoc, service cur if still enabled, otherwise the next enabled one.
    assign sel_idx   = en_pad[cur_q] ? cur_q : next_enabled(en_pad, cur_q, N_CH);
    assign adv_idx   = next_enabled(en_pad, cur_q, N_CH);

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_addr
            if (gi < N_CH) begin : g_used
                assign ch_addr[gi] = CH_ADDR[gi*7 +: 7];
            end else begin : g_unused
                assign ch_addr[gi] = 7'h00;
            end
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        daddr_d   = daddr_q;
        den_d     = 1'b0;
        tmo_cnt_d = tmo_cnt_q;
        cap       = 1'b0;
        store_hit = 1'b0;
        tmo_hit   = 1'b0;
        case (state_q)
            IDLE: begin
                if (drp.eoc && (|ch_en)) begin
                    cur_d   = sel_idx;
                    daddr_d = ch_addr[sel_idx];
                    den_d   = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                tmo_cnt_d = '0;
                state_d   = WAIT_RDY;
            end
            WAIT_RDY: begin
                if (drp.drdy) begin
                    cap     = 1'b1;
                    state_d = STORE;
                end else if (tmo_cnt_q == TMO_W'(TMO - 1)) begin
                    // Flag lands TMO+1 cycles after the den pulse.
                    tmo_hit = 1'b1;
                    cur_d   = adv_idx;
                    state_d = IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            STORE: begin
                store_hit = (chan_q == daddr_q[4:0]);
                cur_d     = adv_idx;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef XADC_SCAN_AVG_EN
    logic [11:0] avg_code [8];
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_avg
            if (gi < N_CH) begin : g_used
                logic [11:0] hist_q [3];
                logic [13:0] sum;
                assign sum = 14'(data_q) + 14'(hist_q[0]) + 14'(hist_q[1]) + 14'(hist_q[2]);
                assign avg_code[gi] = sum[13:2];
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        hist_q[0] <= '0;
                        hist_q[1] <= '0;
                        hist_q[2] <= '0;
                    end else if (store_hit && (cur_q == 3'(gi))) begin
                        hist_q[0] <= data_q;
                        hist_q[1] <= hist_q[0];
                        hist_q[2] <= hist_q[1];
                    end
                end
            end else begin : g_unused
                assign avg_code[gi] = '0;
            end
        end
    endgenerate
    assign new_code = avg_code[cur_q];
`else
    assign new_code = data_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            daddr_q     <= CH_ADDR[6:0];
            den_q       <= 1'b0;
            tmo_cnt_q   <= '0;
            data_q      <= '0;
            chan_q      <= '0;
            smp_valid_q <= 1'b0;
            smp_ch_q    <= '0;
            smp_code_q  <= '0;
            tmo_err_q   <= 1'b0;
            pwm_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            daddr_q     <= daddr_d;
            den_q       <= den_d;
            tmo_cnt_q   <= tmo_cnt_d;
            smp_valid_q <= store_hit;
            tmo_err_q   <= tmo_err_q | tmo_hit;
            pwm_cnt_q   <= pwm_cnt_q + 1'b1;
            if (cap) begin
                data_q <= drp.do_in[15:4];
                chan_q <= drp.channel;
            end
            if (store_hit) begin
                smp_ch_q   <= cur_q;
                smp_code_q <= new_code;
            end
        end
    end

    assign wrap = &pwm_cnt_q;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [11:0] code_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    code_q <= '0;
                else if (store_hit && (cur_q == 3'(gi)))
                    code_q <= new_code;
            end
            xadc_pwm_ch #(
                .PWM_W    (PWM_W),
                .DEADBAND (DEADBAND)
            ) u_pwm (
                .clk    (clk),
                .rst_n  (rst_n),
                .wrap_i (wrap),
                .cnt_i  (pwm_cnt_q),
                .code_i (code_q),
                .en_i   (ch_en[gi]),
                .led_o  (led[gi])
            );
        end
    endgenerate

    assign drp.den   = den_q;
    assign drp.daddr = daddr_q;
    assign smp_valid = smp_valid_q;
    assign smp_ch    = smp_ch_q;
    assign smp_code  = smp_code_q;
    assign tmo_err   = tmo_err_q;
endmodule

// File: tb/tb_xadc_scan_pwm.sv
module tb_xadc_scan_pwm;
    localparam int TMO = 63;

    logic        clk;
    logic        rst_n;
    logic [1:0]  ch_en;
    logic        smp_valid;
    logic [2:0]  smp_ch;
    logic [11:0] smp_code;
    logic        tmo_err;
    logic [1:0]  led;
    int          n_chk;
    int          n_fail;

    xadc_scan_pwm_if drp ();

    xadc_scan_pwm #(
        .N_CH     (2),
        .CH_ADDR  ({7'h10, 7'h1C}),
        .PWM_W    (12),
        .DEADBAND (16),
        .TMO      (TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ch_en     (ch_en),
        .drp       (drp.master),
        .smp_valid (smp_valid),
        .smp_ch    (smp_ch),
        .smp_code  (smp_code),
        .tmo_err   (tmo_err),
        .led       (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic reset_dut();
        rst_n        = 1'b0;
        drp.eoc      = 1'b0;
        drp.drdy     = 1'b0;
        drp.do_in    = 16'h0;
        drp.channel  = 5'h0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One eoc -> den -> drdy transaction; drdy comes 2 cycles after den.
    task automatic xact(input bit use_tbl, input logic [15:0] data, input bit bad_ch,
                        output logic [6:0] addr, output logic vld,
                        output logic [2:0] ch, output logic [11:0] code);
        drp.eoc = 1'b1;
        @(negedge clk);
        drp.eoc = 1'b0;
        n_chk++;
        if (drp.den !== 1'b1) begin
            n_fail++;
            $display("FAIL den_latency: got %b want 1", drp.den);
        end
        addr = drp.daddr;
        repeat (2) @(negedge clk);
        drp.drdy    = 1'b1;
        drp.do_in   = use_tbl ? ((addr == 7'h1C) ? 16'h8000 : 16'h4000) : data;
        drp.channel = bad_ch ? (addr[4:0] ^ 5'h01) : addr[4:0];
        @(negedge clk);
        drp.drdy = 1'b0;
        n_chk++;
        if (smp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL valid_early: got %b want 0", smp_valid);
        end
        @(negedge clk);
        vld  = smp_valid;
        ch   = smp_ch;
        code = smp_code;
    endtask

    task automatic count_led(output int hi0, output int hi1);
        hi0 = 0;
        hi1 = 0;
        repeat (4096) begin
            @(negedge clk);
            if (led[0]) hi0++;
            if (led[1]) hi1++;
        end
    endtask

    task automatic test_reset();
        reset_dut();
        n_chk += 7;
        if (drp.den !== 1'b0) begin n_fail++; $display("FAIL rst_den: got %b want 0", drp.den); end
        if (drp.daddr !== 7'h1C) begin n_fail++; $display("FAIL rst_daddr: got %h want 1c", drp.daddr); end
        if (smp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", smp_valid); end
        if (smp_ch !== 3'd0) begin n_fail++; $display("FAIL rst_ch: got %0d want 0", smp_ch); end
        if (smp_code !== 12'h0) begin n_fail++; $display("FAIL rst_code: got %h want 000", smp_code); end
        if (tmo_err !== 1'b0) begin n_fail++; $display("FAIL rst_tmo: got %b want 0", tmo_err); end
        if (led !== 2'b00) begin n_fail++; $display("FAIL rst_led: got %b want 00", led); end
        $display("test_reset: done");
    endtask

    task automatic test_round_robin();
        logic [6:0]  addr;
        logic        vld;
        logic [2:0]  ch;
        logic [11:0] code;
        logic [6:0]  exp_addr;
        int          hi0, hi1;
        reset_dut();
        ch_en = 2'b11;
        for (int i = 0; i < 4; i++) begin
            exp_addr = (i % 2 == 0) ? 7'h1C : 7'h10;
            xact(1'b1, 16'h0, 1'b0, addr, vld, ch, code);
            $display("rr xact %0d: daddr=%h valid=%b ch=%0d code=%h", i, addr, vld, ch, code);
            n_chk += 4;
            if (addr !== exp_addr) begin n_fail++; $display("FAIL rr_addr: got %h want %h", addr, exp_addr); end
            if (vld !== 1'b1) begin n_fail++; $display("FAIL rr_valid: got %b want 1", vld); end
            if (ch !== 3'(i % 2)) begin n_fail++; $display("FAIL rr_ch: got %0d want %0d", ch, i % 2); end
            if (code !== ((i % 2 == 0) ? 12'h800 : 12'h400)) begin
                n_fail++; $display("FAIL rr_code: got %h want %h", code, (i % 2 == 0) ? 12'h800 : 12'h400);
            end
        end
        repeat (4100) @(negedge clk);
        count_led(hi0, hi1);
        $display("rr duty: led0=%0d led1=%0d of 4096", hi0, hi1);
        n_chk += 2;
        if (hi0 != 2048) begin n_fail++; $display("FAIL rr_duty0: got %0d want 2048", hi0); end
        if (hi1 != 1024) begin n_fail++; $display("FAIL rr_duty1: got %0d want 1024", hi1); end
    endtask

    task automatic test_single();
        logic [6:0]  addr;
        logic        vld;
        logic [2:0]  ch;
        logic [11:0] code;
        int          hi0, hi1;
        reset_dut();
        ch_en = 2'b10;
        for (int i = 0; i < 2; i++) begin
            xact(1'b1, 16'h0, 1'b0, addr, vld, ch, code);
            $display("single xact %0d: daddr=%h valid=%b ch=%0d code=%h", i, addr, vld, ch, code);
            n_chk += 3;
            if (addr !== 7'h10) begin n_fail++; $display("FAIL single_addr: got %h want 10", addr); end
            if (ch !== 3'd1) begin n_fail++; $display("FAIL single_ch: got %0d want 1", ch); end
            if (code !== 12'h400) begin n_fail++; $display("FAIL single_code: got %h want 400", code); end
        end
        ch_en = 2'b11;
        repeat (4100) @(negedge clk);
        count_led(hi0, hi1);
        $display("single duty: led0=%0d led1=%0d of 4096", hi0, hi1);
        n_chk += 2;
        if (hi0 != 0) begin n_fail++; $display("FAIL single_led0: got %0d want 0", hi0); end
        if (hi1 != 1024) begin n_fail++; $display("FAIL single_led1: got %0d want 1024", hi1); end
    endtask

    task automatic test_deadband();
        logic [6:0]  addr;
        logic        vld;
        logic [2:0]  ch;
        logic [11:0] code;
        int          hi0, hi1;
        reset_dut();
        ch_en = 2'b01;
        xact(1'b0, 16'h00F0, 1'b0, addr, vld, ch, code);
        $display("deadband low: valid=%b code=%h", vld, code);
        n_chk += 2;
        if (vld !== 1'b1) begin n_fail++; $display("FAIL db_valid: got %b want 1", vld); end
        if (code !== 12'h00F) begin n_fail++; $display("FAIL db_code: got %h want 00f", code); end
        repeat (4100) @(negedge clk);
        count_led(hi0, hi1);
        n_chk++;
        if (hi0 != 0) begin n_fail++; $display("FAIL db_led_off: got %0d want 0", hi0); end
        xact(1'b0, 16'hFFF0, 1'b0, addr, vld, ch, code);
        $display("deadband full: valid=%b code=%h", vld, code);
        n_chk++;
        if (code !== 12'hFFF) begin n_fail++; $display("FAIL db_full_code: got %h want fff", code); end
        repeat (4100) @(negedge clk);
        count_led(hi0, hi1);
        $display("deadband full: led0 low cycles=%0d", 4096 - hi0);
        n_chk++;
        if (4096 - hi0 != 1) begin n_fail++; $display("FAIL db_full_low: got %0d want 1", 4096 - hi0); end
    endtask

    task automatic test_timeout();
        logic [6:0]  addr;
        logic        vld;
        logic [2:0]  ch;
        logic [11:0] code;
        int          extra_den;
        reset_dut();
        ch_en = 2'b11;
        drp.eoc = 1'b1;
        @(negedge clk);
        drp.eoc = 1'b0;
        n_chk += 2;
        if (drp.den !== 1'b1) begin n_fail++; $display("FAIL tmo_den: got %b want 1", drp.den); end
        if (drp.daddr !== 7'h1C) begin n_fail++; $display("FAIL tmo_daddr: got %h want 1c", drp.daddr); end
        extra_den = 0;
        for (int j = 1; j <= TMO; j++) begin
            @(negedge clk);
            if (j == 10) drp.eoc = 1'b1;
            if (j == 11) drp.eoc = 1'b0;
            if (drp.den === 1'b1) extra_den++;
        end
        n_chk += 2;
        if (extra_den != 0) begin n_fail++; $display("FAIL eoc_overlap_den: got %0d want 0", extra_den); end
        if (tmo_err !== 1'b0) begin n_fail++; $display("FAIL tmo_early: got %b want 0", tmo_err); end
        @(negedge clk);
        $display("timeout: tmo_err=%b at den+%0d", tmo_err, TMO + 1);
        n_chk++;
        if (tmo_err !== 1'b1) begin n_fail++; $display("FAIL tmo_set: got %b want 1", tmo_err); end
        xact(1'b1, 16'h0, 1'b0, addr, vld, ch, code);
        $display("after timeout: daddr=%h valid=%b ch=%0d", addr, vld, ch);
        n_chk += 3;
        if (addr !== 7'h10) begin n_fail++; $display("FAIL tmo_advance: got %h want 10", addr); end
        if (vld !== 1'b1) begin n_fail++; $display("FAIL tmo_next_valid: got %b want 1", vld); end
        if (tmo_err !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky: got %b want 1", tmo_err); end
    endtask

    task automatic test_bad_channel();
        logic [6:0]  addr;
        logic        vld;
        logic [2:0]  ch;
        logic [11:0] code;
        reset_dut();
        ch_en = 2'b11;
        xact(1'b1, 16'h0, 1'b1, addr, vld, ch, code);
        $display("bad channel: daddr=%h valid=%b", addr, vld);
        n_chk++;
        if (vld !== 1'b0) begin n_fail++; $display("FAIL badch_valid: got %b want 0", vld); end
        xact(1'b1, 16'h0, 1'b0, addr, vld, ch, code);
        $display("after bad channel: daddr=%h valid=%b code=%h", addr, vld, code);
        n_chk += 2;
        if (addr !== 7'h10) begin n_fail++; $display("FAIL badch_advance: got %h want 10", addr); end
        if (code !== 12'h400) begin n_fail++; $display("FAIL badch_next_code: got %h want 400", code); end
    endtask

    task automatic test_reset_mid();
        logic [6:0]  addr;
        logic        vld;
        logic [2:0]  ch;
        logic [11:0] code;
        int          late;
        reset_dut();
        ch_en = 2'b11;
        xact(1'b1, 16'h0, 1'b0, addr, vld, ch, code);
        drp.eoc = 1'b1;
        @(negedge clk);
        drp.eoc = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        $display("mid reset: den=%b daddr=%h valid=%b code=%h tmo=%b led=%b",
                 drp.den, drp.daddr, smp_valid, smp_code, tmo_err, led);
        n_chk += 4;
        if (drp.daddr !== 7'h1C) begin n_fail++; $display("FAIL mid_daddr: got %h want 1c", drp.daddr); end
        if (smp_code !== 12'h0) begin n_fail++; $display("FAIL mid_code: got %h want 000", smp_code); end
        if (drp.den !== 1'b0) begin n_fail++; $display("FAIL mid_den: got %b want 0", drp.den); end
        if (led !== 2'b00) begin n_fail++; $display("FAIL mid_led: got %b want 00", led); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drp.drdy    = 1'b1;
        drp.do_in   = 16'h4000;
        drp.channel = 5'h10;
        @(negedge clk);
        drp.drdy = 1'b0;
        late = 0;
        repeat (3) begin
            @(negedge clk);
            if (smp_valid === 1'b1 || drp.den === 1'b1) late++;
        end
        n_chk++;
        if (late != 0) begin n_fail++; $display("FAIL late_drdy: got %0d events want 0", late); end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        ch_en  = 2'b00;
        rst_n  = 1'b0;
        test_reset();
        test_round_robin();
        test_single();
        test_deadband();
        test_timeout();
        test_bad_channel();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
